// File: rtl/gpio_irq_controller.sv
// GPIO peripheral: switches, LEDs, 7-seg, debounced buttons with maskable edge IRQ.
// Latency: writes land on the strobe edge, reads register one edge later, buttons 2+DEBOUNCE_CYCLES.
// Backpressure: none, bus_stall is tied low and every access completes in one cycle.
module gpio_irq_controller #(
    parameter int SW_WIDTH        = 32,
    parameter int LED_WIDTH       = 16,
    parameter int BTN_COUNT       = 4,
    parameter int DPY_DIGITS      = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_read,
    input  logic                    bus_write,
    input  logic [ADDR_WIDTH-1:0]   bus_address,
    input  logic [31:0]             bus_data_wr,
    input  logic [3:0]              bus_mask,
    output logic [31:0]             bus_data_rd,
    output logic                    bus_stall,
    input  logic [SW_WIDTH-1:0]     dip_sw,
    input  logic [BTN_COUNT-1:0]    touch_btn,
    output logic [LED_WIDTH-1:0]    leds,
    output logic [8*DPY_DIGITS-1:0] dpy,
    output logic                    irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WI    = ADDR_WIDTH - 2;
    localparam logic [WI-1:0] W_SW   = WI'(0);
    localparam logic [WI-1:0] W_DPY  = WI'(1);
    localparam logic [WI-1:0] W_LED  = WI'(2);
    localparam logic [WI-1:0] W_BTN  = WI'(3);
    localparam logic [WI-1:0] W_PEND = WI'(4);
    localparam logic [WI-1:0] W_EN   = WI'(5);
    localparam logic [WI-1:0] W_EDGE = WI'(6);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WI-1:0]          word_idx;
    logic [31:0]            wmask;
    logic [31:0]            rd_mux;
    logic [31:0]            dpy_reg;
    logic [LED_WIDTH-1:0]   led_reg;
    logic [BTN_COUNT-1:0]   pend, en, edge_sel, btn_deb, deb_next;
    logic [BTN_COUNT-1:0]   sync1, sync2, evt, pend_clr;
    logic [CNT_W-1:0]       cnt [BTN_COUNT];
    logic                   unused_addr;

    assign word_idx    = bus_address[ADDR_WIDTH-1:2];
    assign unused_addr = ^bus_address[1:0];
    assign wmask       = {{8{bus_mask[3]}}, {8{bus_mask[2]}}, {8{bus_mask[1]}}, {8{bus_mask[0]}}};
    assign bus_stall   = 1'b0;
    assign leds        = led_reg;

    function automatic logic [7:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 8'h7E;  4'h1: hex7 = 8'h12;  4'h2: hex7 = 8'hBC;  4'h3: hex7 = 8'h9E;
            4'h4: hex7 = 8'hD2;  4'h5: hex7 = 8'hCE;  4'h6: hex7 = 8'hEE;  4'h7: hex7 = 8'h1A;
            4'h8: hex7 = 8'hFE;  4'h9: hex7 = 8'hDE;  4'hA: hex7 = 8'hFA;  4'hB: hex7 = 8'hE6;
            4'hC: hex7 = 8'h6C;  4'hD: hex7 = 8'hB6;  4'hE: hex7 = 8'hEC;  default: hex7 = 8'hE8;
        endcase
    endfunction

    always_comb begin
        dpy = '0;
        for (int i = 0; i < DPY_DIGITS; i++)
            dpy[8*i +: 8] = dpy_reg[31] ? hex7(dpy_reg[4*i +: 4]) : dpy_reg[8*i +: 8];
    end

    // The counter compares the two synchroniser stages, so the run of stable
    // cycles is measured on the value about to appear at the synchroniser output.
    always_comb begin
        deb_next = btn_deb;
        for (int i = 0; i < BTN_COUNT; i++)
            if (sync1[i] == sync2[i] && cnt[i] >= CNT_FIRE)
                deb_next[i] = sync2[i];
    end

    assign evt      = (edge_sel & deb_next & ~btn_deb) | (~edge_sel & ~deb_next & btn_deb);
    assign pend_clr = (bus_write && word_idx == W_PEND) ?
                      (bus_data_wr[BTN_COUNT-1:0] & wmask[BTN_COUNT-1:0]) : '0;

    always_comb begin
        rd_mux = '0;
        case (word_idx)
            W_SW:    rd_mux[SW_WIDTH-1:0]  = dip_sw;
            W_DPY:   rd_mux                = dpy_reg;
            W_LED:   rd_mux[LED_WIDTH-1:0] = led_reg;
            W_BTN:   rd_mux[BTN_COUNT-1:0] = btn_deb;
            W_PEND:  rd_mux[BTN_COUNT-1:0] = pend;
            W_EN:    rd_mux[BTN_COUNT-1:0] = en;
            W_EDGE:  rd_mux[BTN_COUNT-1:0] = edge_sel;
            default: rd_mux                = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            btn_deb <= '0;
            for (int i = 0; i < BTN_COUNT; i++)
                cnt[i] <= '0;
        end else begin
            sync1   <= touch_btn;
            sync2   <= sync1;
            btn_deb <= deb_next;
            for (int i = 0; i < BTN_COUNT; i++) begin
                if (sync1[i] != sync2[i])
                    cnt[i] <= '0;
                else if (cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpy_reg     <= '0;
            led_reg     <= '0;
            en          <= '0;
            edge_sel    <= '0;
            pend        <= '0;
            irq         <= 1'b0;
            bus_data_rd <= '0;
        end else begin
            if (bus_write) begin
                case (word_idx)
                    W_DPY:   dpy_reg  <= (dpy_reg & ~wmask) | (bus_data_wr & wmask);
                    W_LED:   led_reg  <= (led_reg & ~wmask[LED_WIDTH-1:0]) |
                                         (bus_data_wr[LED_WIDTH-1:0] & wmask[LED_WIDTH-1:0]);
                    W_EN:    en       <= (en & ~wmask[BTN_COUNT-1:0]) |
                                         (bus_data_wr[BTN_COUNT-1:0] & wmask[BTN_COUNT-1:0]);
                    W_EDGE:  edge_sel <= (edge_sel & ~wmask[BTN_COUNT-1:0]) |
                                         (bus_data_wr[BTN_COUNT-1:0] & wmask[BTN_COUNT-1:0]);
                    default: ;
                endcase
            end
            // New events are OR'd in after the clear so a same-cycle set wins.
            pend <= (pend & ~pend_clr) | evt;
            irq  <= |(pend & en);
            if (bus_read && !bus_write)
                bus_data_rd <= rd_mux;
        end
    end
endmodule

// File: tb/tb_gpio_irq_controller.sv
// Directed bench for gpio_irq_controller: register table plus debounce/IRQ/reset sequences.
module tb_gpio_irq_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_read, bus_write;
    logic [4:0]  bus_address;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_mask;
    logic [31:0] bus_data_rd;
    logic        bus_stall;
    logic [31:0] dip_sw;
    logic [3:0]  touch_btn;
    logic [15:0] leds;
    logic [15:0] dpy;
    logic        irq;

    int n_checks = 0;
    int n_bad    = 0;

    gpio_irq_controller dut (
        .clk(clk), .rst_n(rst_n), .bus_read(bus_read), .bus_write(bus_write),
        .bus_address(bus_address), .bus_data_wr(bus_data_wr), .bus_mask(bus_mask),
        .bus_data_rd(bus_data_rd), .bus_stall(bus_stall), .dip_sw(dip_sw),
        .touch_btn(touch_btn), .leds(leds), .dpy(dpy), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdat;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
        logic [15:0] exp_leds;
        logic [15:0] exp_dpy;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_write   = 1'b1;
        bus_address = a;
        bus_data_wr = d;
        bus_mask    = m;
        tick();
        bus_write   = 1'b0;
        bus_mask    = 4'b0000;
    endtask

    task automatic do_read(input logic [4:0] a);
        bus_read    = 1'b1;
        bus_address = a;
        tick();
        bus_read    = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h12345678, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 5'h04, 32'h0000CAFE, 4'hF, 32'h0000CAFE, 16'h0000, 16'hCAFE};
        vecs[2]  = '{1'b1, 5'h04, 32'h800000FE, 4'hF, 32'h800000FE, 16'h0000, 16'hE8EC};
        vecs[3]  = '{1'b1, 5'h08, 32'h00002333, 4'h1, 32'h00000033, 16'h0033, 16'hE8EC};
        vecs[4]  = '{1'b1, 5'h08, 32'h00002333, 4'h2, 32'h00002333, 16'h2333, 16'hE8EC};
        vecs[5]  = '{1'b1, 5'h08, 32'hFFFFFFFF, 4'hC, 32'h00002333, 16'h2333, 16'hE8EC};
        vecs[6]  = '{1'b1, 5'h04, 32'h80000012, 4'h1, 32'h80000012, 16'h2333, 16'h12BC};
        vecs[7]  = '{1'b1, 5'h04, 32'h00000000, 4'h8, 32'h00000012, 16'h2333, 16'h0012};
        vecs[8]  = '{1'b1, 5'h14, 32'hFFFFFFFF, 4'hF, 32'h0000000F, 16'h2333, 16'h0012};
        vecs[9]  = '{1'b1, 5'h18, 32'h00000005, 4'h1, 32'h00000005, 16'h2333, 16'h0012};
        vecs[10] = '{1'b1, 5'h1C, 32'h12345678, 4'hF, 32'h00000000, 16'h2333, 16'h0012};
        vecs[11] = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h00000000, 16'h2333, 16'h0012};
        vecs[12] = '{1'b1, 5'h10, 32'h0000000F, 4'hF, 32'h00000000, 16'h2333, 16'h0012};
        vecs[13] = '{1'b1, 5'h14, 32'h00000001, 4'hF, 32'h00000001, 16'h2333, 16'h0012};
        vecs[14] = '{1'b1, 5'h18, 32'h00000001, 4'hF, 32'h00000001, 16'h2333, 16'h0012};

        rst_n = 1'b0; bus_read = 1'b0; bus_write = 1'b0; bus_address = '0;
        bus_data_wr = '0; bus_mask = '0; dip_sw = 32'h12345678; touch_btn = '0;
        #3;
        check("rst_rd",    bus_data_rd, 32'h0);
        check("rst_leds",  {16'h0, leds}, 32'h0);
        check("rst_dpy",   {16'h0, dpy}, 32'h0);
        check("rst_irq",   {31'h0, irq}, 32'h0);
        check("rst_stall", {31'h0, bus_stall}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdat, vecs[i].mask);
            do_read(vecs[i].addr);
            check($sformatf("v%0d_rd", i),    bus_data_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_leds", i),  {16'h0, leds}, {16'h0, vecs[i].exp_leds});
            check($sformatf("v%0d_dpy", i),   {16'h0, dpy}, {16'h0, vecs[i].exp_dpy});
            check($sformatf("v%0d_stall", i), {31'h0, bus_stall}, 32'h0);
        end

        // Read and write together: write lands, read data holds.
        do_read(5'h00);
        check("rw_pre_rd", bus_data_rd, 32'h12345678);
        bus_read = 1'b1;
        do_write(5'h08, 32'h0000ABCD, 4'hF);
        bus_read = 1'b0;
        check("rw_hold_rd", bus_data_rd, 32'h12345678);
        check("rw_leds", {16'h0, leds}, 32'h0000ABCD);
        tick(); tick();
        check("rd_hold_idle", bus_data_rd, 32'h12345678);

        // Short glitch must be filtered.
        touch_btn[0] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        touch_btn[0] = 1'b0;
        for (int k = 0; k < 25; k++) tick();
        check("glitch_irq", {31'h0, irq}, 32'h0);
        do_read(5'h0C);
        check("glitch_btn", bus_data_rd, 32'h0);
        do_read(5'h10);
        check("glitch_pend", bus_data_rd, 32'h0);

        // Held press: PEND on edge 18, irq on edge 19.
        touch_btn[0] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) check("press_irq_e18", {31'h0, irq}, 32'h0);
            if (k == 19) check("press_irq_e19", {31'h0, irq}, 32'h1);
        end
        do_read(5'h0C);
        check("press_btn", bus_data_rd, 32'h1);
        do_read(5'h10);
        check("press_pend", bus_data_rd, 32'h1);

        do_write(5'h10, 32'h1, 4'b0010);
        tick();
        check("w1c_nomask_irq", {31'h0, irq}, 32'h1);
        do_read(5'h10);
        check("w1c_nomask_pend", bus_data_rd, 32'h1);

        do_write(5'h10, 32'h1, 4'b0001);
        tick();
        check("w1c_irq", {31'h0, irq}, 32'h0);
        do_read(5'h10);
        check("w1c_pend", bus_data_rd, 32'h0);

        // Falling event on the same edge as a clear: set wins.
        do_write(5'h18, 32'h0, 4'b0001);
        touch_btn[0] = 1'b0;
        for (int k = 0; k < 17; k++) tick();
        do_write(5'h10, 32'h1, 4'b0001);
        tick();
        check("setwins_irq", {31'h0, irq}, 32'h1);
        do_read(5'h10);
        check("setwins_pend", bus_data_rd, 32'h1);
        do_read(5'h0C);
        check("release_btn", bus_data_rd, 32'h0);

        do_write(5'h14, 32'h0, 4'b0001);
        tick();
        check("en_off_irq", {31'h0, irq}, 32'h0);
        do_write(5'h14, 32'h1, 4'b0001);
        check("en_on_irq_same", {31'h0, irq}, 32'h0);
        tick();
        check("en_on_irq_next", {31'h0, irq}, 32'h1);

        // Reset mid-debounce with irq high.
        do_read(5'h10);
        touch_btn[0] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_irq",  {31'h0, irq}, 32'h0);
        check("arst_leds", {16'h0, leds}, 32'h0);
        check("arst_dpy",  {16'h0, dpy}, 32'h0);
        check("arst_rd",   bus_data_rd, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        bus_read = 1'b1;
        bus_address = 5'h0C;
        for (int k = 1; k <= 19; k++) begin
            tick();
            check($sformatf("post_rst_btn_e%0d", k), bus_data_rd, (k == 19) ? 32'h1 : 32'h0);
        end
        bus_read = 1'b0;
        do_read(5'h10);
        check("post_rst_pend", bus_data_rd, 32'h0);
        do_read(5'h14);
        check("post_rst_en", bus_data_rd, 32'h0);
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
